// File: rtl/vde_addrgen.sv
// Frame-buffer read-address generator driven by the timing controller's data-enable.
// Supports integer pixel/line replication and double-buffered frame banks.
module vde_addrgen #(
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned H_DIV     = 2,
    parameter int unsigned V_DIV     = 2,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned BANK_SIZE = 76800
) (
    input  logic              clk,
    input  logic              Reset_Main,
    input  logic              VtcVde,
    input  logic              VtcVsync,
    input  logic              bank_sel,
    output logic [ADDR_W-1:0] addr,
    output logic              en_ram,
    output logic              line_done,
    output logic              frame_done,
    output logic              ovf_err
);

    localparam int unsigned SRC_W  = H_ACTIVE / H_DIV;
    localparam int unsigned SRC_H  = V_ACTIVE / V_DIV;
    localparam int unsigned HSUB_W = (H_DIV > 1) ? $clog2(H_DIV) : 1;
    localparam int unsigned COL_W  = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int unsigned VSUB_W = (V_DIV > 1) ? $clog2(V_DIV) : 1;
    localparam int unsigned ROW_W  = (SRC_H > 1) ? $clog2(SRC_H) : 1;
    localparam int unsigned PIX_W  = $clog2(H_ACTIVE + 1);

    localparam logic [HSUB_W-1:0] HSUB_LAST = HSUB_W'(H_DIV - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(SRC_W - 1);
    localparam logic [VSUB_W-1:0] VSUB_LAST = VSUB_W'(V_DIV - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(SRC_H - 1);
    localparam logic [PIX_W-1:0]  PIX_MAX   = PIX_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] BANK_A    = ADDR_W'(BANK_SIZE);
    localparam logic [ADDR_W-1:0] SRC_W_A   = ADDR_W'(SRC_W);

    logic [HSUB_W-1:0] hsub_q, hsub_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [VSUB_W-1:0] vsub_q, vsub_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic              bank_q, bank_d;
    logic              vde_dly_q, vs_dly_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              en_q, en_d;
    logic              line_done_q, line_done_d;
    logic              frame_done_q, frame_done_d;
    logic              ovf_q, ovf_d;

    logic line_end, frame_start;

    assign line_end    = vde_dly_q & ~VtcVde;
    assign frame_start = ~vs_dly_q & VtcVsync;

    always_comb begin
        hsub_d       = hsub_q;
        col_d        = col_q;
        vsub_d       = vsub_q;
        row_d        = row_q;
        pix_d        = pix_q;
        bank_d       = bank_q;
        addr_d       = addr_q;
        en_d         = 1'b0;
        line_done_d  = 1'b0;
        frame_done_d = 1'b0;
        ovf_d        = ovf_q;

        if (line_end) begin
            line_done_d = 1'b1;
            hsub_d      = '0;
            col_d       = '0;
            pix_d       = '0;
            if (vsub_q == VSUB_LAST) begin
                vsub_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                vsub_d = vsub_q + VSUB_W'(1);
            end
        end

        // Frame start overrides line-end bookkeeping and feeds a coincident pixel.
        if (frame_start) begin
            hsub_d = '0;
            col_d  = '0;
            vsub_d = '0;
            row_d  = '0;
            pix_d  = '0;
            bank_d = bank_sel;
        end

        if (VtcVde) begin
            en_d   = 1'b1;
            addr_d = BASE_A + (bank_d ? BANK_A : '0)
                   + ADDR_W'(row_d) * SRC_W_A + ADDR_W'(col_d);
            if (hsub_d == HSUB_LAST) begin
                hsub_d = '0;
                col_d  = (col_d == COL_LAST) ? '0 : col_d + COL_W'(1);
            end else begin
                hsub_d = hsub_d + HSUB_W'(1);
            end
            if (pix_d == PIX_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pix_d = pix_d + PIX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_Main) begin
        if (!Reset_Main) begin
            hsub_q       <= '0;
            col_q        <= '0;
            vsub_q       <= '0;
            row_q        <= '0;
            pix_q        <= '0;
            bank_q       <= 1'b0;
            vde_dly_q    <= 1'b0;
            vs_dly_q     <= 1'b0;
            addr_q       <= '0;
            en_q         <= 1'b0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            hsub_q       <= hsub_d;
            col_q        <= col_d;
            vsub_q       <= vsub_d;
            row_q        <= row_d;
            pix_q        <= pix_d;
            bank_q       <= bank_d;
            vde_dly_q    <= VtcVde;
            vs_dly_q     <= VtcVsync;
            addr_q       <= addr_d;
            en_q         <= en_d;
            line_done_q  <= line_done_d;
            frame_done_q <= frame_done_d;
            ovf_q        <= ovf_d;
        end
    end

    assign addr       = addr_q;
    assign en_ram     = en_q;
    assign line_done  = line_done_q;
    assign frame_done = frame_done_q;
    assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_vde_addrgen.sv
// Randomised scoreboard bench for vde_addrgen: a frame/line/pixel-position model
// predicts every address and strobe; a negedge monitor compares DUT outputs.
module tb_vde_addrgen;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned H_ACTIVE  = 8;
    localparam int unsigned V_ACTIVE  = 4;
    localparam int unsigned H_DIV     = 2;
    localparam int unsigned V_DIV     = 2;
    localparam int unsigned BASE_ADDR = 0;
    localparam int unsigned BANK_SIZE = 8;
    localparam int unsigned SRC_W     = H_ACTIVE / H_DIV;

    logic              clk = 1'b0;
    logic              Reset_Main = 1'b0;
    logic              VtcVde = 1'b0;
    logic              VtcVsync = 1'b0;
    logic              bank_sel = 1'b0;
    logic [ADDR_W-1:0] addr;
    logic              en_ram, line_done, frame_done, ovf_err;

    vde_addrgen #(
        .ADDR_W   (ADDR_W),
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .H_DIV    (H_DIV),
        .V_DIV    (V_DIV),
        .BASE_ADDR(BASE_ADDR),
        .BANK_SIZE(BANK_SIZE)
    ) dut (
        .clk       (clk),
        .Reset_Main(Reset_Main),
        .VtcVde    (VtcVde),
        .VtcVsync  (VtcVsync),
        .bank_sel  (bank_sel),
        .addr      (addr),
        .en_ram    (en_ram),
        .line_done (line_done),
        .frame_done(frame_done),
        .ovf_err   (ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic              ovf;
    } pix_t;
    typedef struct packed {
        logic fd;
        logic ovf;
    } ld_t;

    pix_t pix_q[$];
    ld_t  ld_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Model state: pixels seen in this line, display line in frame, bank, sticky error.
    int m_px, m_ln;
    bit m_bank, m_pvde, m_pvs, m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_px = 0; m_ln = 0; m_bank = 0; m_pvde = 0; m_pvs = 0; m_ovf = 0;
    endtask

    task automatic model_step(input bit vde, input bit vs, input bit bsel);
        int a;
        if (m_pvde && !vde) begin
            ld_q.push_back(ld_t'{fd: (m_ln == V_ACTIVE - 1), ovf: m_ovf});
            m_ln = (m_ln + 1) % V_ACTIVE;
            m_px = 0;
        end
        if (vs && !m_pvs) begin
            m_px = 0; m_ln = 0; m_bank = bsel;
        end
        if (vde) begin
            if (m_px >= H_ACTIVE) m_ovf = 1;
            a = BASE_ADDR + m_bank * BANK_SIZE + (m_ln / V_DIV) * SRC_W
              + (m_px / H_DIV) % SRC_W;
            pix_q.push_back(pix_t'{a: ADDR_W'(a), ovf: m_ovf});
            m_px++;
        end
        m_pvde = vde;
        m_pvs  = vs;
    endtask

    task automatic step(input bit vde, input bit vs);
        @(posedge clk);
        #1;
        VtcVde   = vde;
        VtcVsync = vs;
        bank_sel = 1'($urandom_range(0, 1));
        model_step(vde, vs, bank_sel);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        Reset_Main = 1'b0;
        VtcVde     = 1'b0;
        VtcVsync   = 1'b0;
        #1;
        chk("rst_addr", 32'(addr), 0);
        chk("rst_en_ram", 32'(en_ram), 0);
        chk("rst_line_done", 32'(line_done), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_ovf_err", 32'(ovf_err), 0);
        pix_q.delete();
        ld_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        Reset_Main = 1'b1;
    endtask

    always @(negedge clk) begin
        if (Reset_Main) begin
            if (en_ram) begin
                if (pix_q.size() == 0) begin
                    chk("en_ram_unexpected", 32'(en_ram), 0);
                end else begin
                    pix_t e;
                    e = pix_q.pop_front();
                    chk("addr", 32'(addr), 32'(e.a));
                    chk("ovf_err_pix", 32'(ovf_err), 32'(e.ovf));
                end
            end
            if (line_done) begin
                if (ld_q.size() == 0) begin
                    chk("line_done_unexpected", 32'(line_done), 0);
                end else begin
                    ld_t l;
                    l = ld_q.pop_front();
                    chk("frame_done", 32'(frame_done), 32'(l.fd));
                    chk("ovf_err_line", 32'(ovf_err), 32'(l.ovf));
                end
            end else if (frame_done) begin
                chk("frame_done_alone", 32'(frame_done), 0);
            end
        end
    end

    initial begin
        #1000000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        int n, r;
        bit co;
        model_reset();
        do_reset();
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 2)) step(0, 0);
            repeat (3) step(0, 1);
            step(0, 0);
            co = (f % 4 == 3);
            for (int l = 0; l < V_ACTIVE; l++) begin
                repeat ($urandom_range(1, 3)) step(0, 0);
                r = $urandom_range(0, 7);
                if (r == 0) n = $urandom_range(1, H_ACTIVE - 1);
                else if (r == 1 && f >= 4) n = $urandom_range(H_ACTIVE + 1, H_ACTIVE + 3);
                else n = H_ACTIVE;
                for (int p = 0; p < n; p++) begin
                    if (f == 20 && l == 2 && p == 4) do_reset();
                    step(1, co && l == 2 && p == 3);
                end
            end
        end
        repeat (4) step(0, 0);
        chk("pix_queue_drained", 32'(pix_q.size()), 0);
        chk("line_queue_drained", 32'(ld_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vde_addrgen.md
# vde_addrgen

Parametrised RAM read-address generator for the video output path, driven by the timing controller's data-enable. It produces one frame-buffer address per active pixel and supports integer pixel and line replication (upscaling) plus double-buffered frame banks. Line-done and frame-done strobes and an overrun flag are provided for the frame-buffer controller. With H_DIV = V_DIV = 1 it produces a plain linear count of H_ACTIVE×V_ACTIVE words.

## Interface

Parameters:
- ADDR_W, 18, address width; must hold BASE_ADDR + 2·BANK_SIZE − 1.
- H_ACTIVE, 640, active pixels per display line.
- V_ACTIVE, 480, active lines per display frame.
- H_DIV, 2, horizontal replication factor; must divide H_ACTIVE evenly.
- V_DIV, 2, vertical replication factor; must divide V_ACTIVE evenly.
- BASE_ADDR, 0, address of bank 0, word 0.
- BANK_SIZE, 76800, word offset of bank 1; must be ≥ SRC_W·SRC_H.
- Derived values: SRC_W = H_ACTIVE/H_DIV and SRC_H = V_ACTIVE/V_DIV.

Ports:
- clk, in, 1, the single clock; all logic is on the rising edge.
- Reset_Main, in, 1, asynchronous, active-low reset.
- VtcVde, in, 1, active-video data enable from the timing controller.
- VtcVsync, in, 1, vertical sync, active-high; its rising edge starts a frame.
- bank_sel, in, 1, frame-bank request; sampled only at frame start.
- addr, out, ADDR_W, registered RAM read address.
- en_ram, out, 1, registered RAM enable, qualifying addr.
- line_done, out, 1, one-cycle pulse at the end of each display line.
- frame_done, out, 1, one-cycle pulse at the end of the last display line.
- ovf_err, out, 1, sticky flag: a line had more than H_ACTIVE active pixels.

## Operation

- Internal counters:
  - hsub: 0..H_DIV−1
  - col: 0..SRC_W−1
  - vsub: 0..V_DIV−1
  - row: 0..SRC_H−1
  - bank_q: 1 bit
  - vde_d, vs_d: 1-cycle input delays for edge detection
  - pix: 0..H_ACTIVE, active-pixel count for the current line
- Address arithmetic: addr = BASE_ADDR + bank_q·BANK_SIZE + row·SRC_W + col. It is computed at ADDR_W width with no wrap; the parameter constraints guarantee it fits.
- Cycle with VtcVde=1:
  - en_ram ← 1 and addr ← the current address.
  - hsub advances. When hsub=H_DIV−1, hsub ← 0 and col advances; col wraps SRC_W−1→0.
  - pix increments. If pix is already H_ACTIVE, ovf_err ← 1 and pix holds its value.
- Cycle with VtcVde=0: en_ram ← 0 and addr holds its value.
- Line end is the cycle where vde_d=1 and VtcVde=0:
  - hsub, col and pix ← 0; line_done ← 1.
  - vsub advances. When vsub=V_DIV−1, vsub ← 0 and row advances.
  - If row=SRC_H−1 and vsub=V_DIV−1: row ← 0 and frame_done ← 1, in the same cycle as line_done.
- Frame start is the cycle where vs_d=0 and VtcVsync=1:
  - hsub, col, vsub, row and pix ← 0.
  - bank_q ← bank_sel.
  - ovf_err is not cleared.
- Simultaneous frame start and VtcVde=1: frame start wins. The emitted address is that of pixel 0 of the new bank, and counters go to the post-pixel-0 state.
- Simultaneous frame start and line end: frame start wins. line_done still pulses; frame_done pulses only if its condition was met.
- Short line (fewer than H_ACTIVE pixels): no error. Counters restart at the next line.
- ovf_err is cleared only by reset.
- Reset (asynchronous, at any time, including mid-line):
  - addr=0, en_ram=0, line_done=0, frame_done=0, ovf_err=0.
  - All counters, bank_q, vde_d and vs_d = 0.
  - After release, the first address is BASE_ADDR + bank_sel-independent bank 0. bank_q stays 0 until the first frame start.

## Timing

- Latency: 1 cycle from VtcVde to en_ram/addr. The address for the pixel with VtcVde high in cycle n is on addr in cycle n+1.
- line_done and frame_done are asserted in the cycle after the last active pixel's cycle+1, i.e. registered on the falling-edge detect. Each is exactly 1 cycle wide.
- bank_sel setup: it must be stable in the cycle VtcVsync rises. Changes at any other time have no effect until the next frame start.
- Throughput: one address per clk while VtcVde=1, with no stall input.

## Test plan

- H_ACTIVE=8, V_ACTIVE=4, H_DIV=2, V_DIV=2, BASE_ADDR=0, BANK_SIZE=8; one Vsync, then 4 lines of 8 VtcVde cycles:
  - Line 0 addr: 0,0,1,1,2,2,3,3. Line 1 repeats it. Lines 2–3: 4,4,5,5,6,6,7,7.
  - line_done pulses ×4; frame_done pulses once, together with line 3's line_done.
- Same configuration, bank_sel=1 at the Vsync rising edge: addresses are offset by 8 (8..15). A bank_sel toggle mid-frame has no effect.
- H_ACTIVE=320, V_ACTIVE=480, H_DIV=V_DIV=1, ADDR_W=18:
  - addr runs 0..153599 over the frame and returns to 0 on the next frame.
  - frame_done pulses once per frame.
- Overrun: a 10-pixel VtcVde burst with H_ACTIVE=8 sets ovf_err=1 on the 9th pixel. The flag stays 1 across the next Vsync and clears only on Reset_Main=0.
- Reset asserted mid-line at row 1, col 2:
  - All outputs go to 0 immediately, without waiting for clk.
  - After release plus Vsync, the first address is 0 and en_ram follows VtcVde with 1-cycle lag.
- Vsync rising in the same cycle as VtcVde=1 mid-frame: the emitted addr is BASE_ADDR + bank offset, and the next pixel follows the post-pixel-0 sequence.
